// File: rtl/arbitro_mux_4x1_rr.sv
// Round-robin arbiter sharing one 4:1 data path among four requesters.
// Grants are held until release, or until the time slot expires while others wait.

module mux_4x1_n #(
    parameter int BITS = 7
) (
    input  logic [1:0]      sel,
    input  logic [BITS-1:0] d0,
    input  logic [BITS-1:0] d1,
    input  logic [BITS-1:0] d2,
    input  logic [BITS-1:0] d3,
    output logic [BITS-1:0] y
);
    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end
endmodule

module arbitro_mux_4x1_rr #(
    parameter int BITS = 7,
    parameter int SLOT = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [3:0]      req,
    input  logic [BITS-1:0] D0,
    input  logic [BITS-1:0] D1,
    input  logic [BITS-1:0] D2,
    input  logic [BITS-1:0] D3,
    output logic [3:0]      grant,
    output logic [1:0]      sel,
    output logic            valid,
    output logic [BITS-1:0] dout
);
    localparam int CW = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SLOT - 1);

    typedef enum logic [1:0] {OCIOSO, CONCEDE, TROCA} state_t;

    state_t          state;
    logic [1:0]      ptr;
    logic [CW-1:0]   cnt;
    logic [7:0]      req_rot;
    logic [1:0]      offset;
    logic [1:0]      win;
    logic [BITS-1:0] mux_y;

    // Rotate requests so the scan always starts at ptr, then priority-encode.
    always_comb begin
        req_rot = {req, req} >> ptr;
        if (req_rot[0])      offset = 2'd0;
        else if (req_rot[1]) offset = 2'd1;
        else if (req_rot[2]) offset = 2'd2;
        else                 offset = 2'd3;
        win = ptr + offset;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= OCIOSO;
            grant <= '0;
            sel   <= '0;
            valid <= 1'b0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                OCIOSO, TROCA: begin
                    if (|req) begin
                        state <= CONCEDE;
                        grant <= 4'b0001 << win;
                        sel   <= win;
                        valid <= 1'b1;
                        cnt   <= '0;
                        ptr   <= win + 2'd1;
                    end else begin
                        state <= OCIOSO;
                        grant <= '0;
                        valid <= 1'b0;
                    end
                end
                CONCEDE: begin
                    // Release and slot-expiry preemption both pass through TROCA.
                    if (!req[sel] || (cnt == CNT_MAX && |(req & ~grant))) begin
                        state <= TROCA;
                        grant <= '0;
                        valid <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= OCIOSO;
                    grant <= '0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    mux_4x1_n #(.BITS(BITS)) u_mux (
        .sel (sel),
        .d0  (D0),
        .d1  (D1),
        .d2  (D2),
        .d3  (D3),
        .y   (mux_y)
    );

    assign dout = valid ? mux_y : '0;

endmodule

// File: tb/tb_arbitro_mux_4x1_rr.sv
// Scoreboard bench for arbitro_mux_4x1_rr: SLOT=8 instance plus a SLOT=1 instance.

module tb_arbitro_mux_4x1_rr;
    logic       clock;
    logic       reset;
    logic [3:0] req0, req1;
    logic [6:0] D0, D1, D2, D3;
    logic [3:0] grant0, grant1;
    logic [1:0] sel0, sel1;
    logic       valid0, valid1;
    logic [6:0] dout0, dout1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int c;

    typedef struct {
        int         cyc;
        logic [3:0] g;
        logic [1:0] s;
        logic [6:0] d;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    arbitro_mux_4x1_rr #(.BITS(7), .SLOT(8)) dut0 (
        .clock (clock), .reset (reset), .req (req0),
        .D0 (D0), .D1 (D1), .D2 (D2), .D3 (D3),
        .grant (grant0), .sel (sel0), .valid (valid0), .dout (dout0)
    );

    arbitro_mux_4x1_rr #(.BITS(7), .SLOT(1)) dut1 (
        .clock (clock), .reset (reset), .req (req1),
        .D0 (D0), .D1 (D1), .D2 (D2), .D3 (D3),
        .grant (grant1), .sel (sel1), .valid (valid1), .dout (dout1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, expv);
        end
    endtask

    task automatic push(input int inst, input int first, input int n,
                        input int idx, input logic [6:0] d);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.cyc = first + i;
            e.g   = 4'b0001 << idx;
            e.s   = 2'(idx);
            e.d   = d;
            if (inst == 0) q0.push_back(e);
            else           q1.push_back(e);
        end
    endtask

    task automatic monitor(input int inst, input logic [3:0] g, input logic [1:0] s,
                           input logic v, input logic [6:0] d);
        exp_t e;
        int   n;
        n = (inst == 0) ? q0.size() : q1.size();
        if (n > 0) e = (inst == 0) ? q0[0] : q1[0];
        if (v) begin
            if (n == 0) begin
                chk($sformatf("dut%0d_unexpected_grant@%0d", inst, cyc), g, 0);
            end else begin
                if (inst == 0) void'(q0.pop_front());
                else           void'(q1.pop_front());
                chk($sformatf("dut%0d_grant_cycle@%0d", inst, cyc), cyc, e.cyc);
                chk($sformatf("dut%0d_grant@%0d", inst, cyc), g, e.g);
                chk($sformatf("dut%0d_sel@%0d", inst, cyc), s, e.s);
                chk($sformatf("dut%0d_dout@%0d", inst, cyc), d, e.d);
            end
        end else begin
            chk($sformatf("dut%0d_idle_grant@%0d", inst, cyc), g, 0);
            chk($sformatf("dut%0d_idle_dout@%0d", inst, cyc), d, 0);
            if (n > 0 && e.cyc <= cyc) begin
                chk($sformatf("dut%0d_missed_grant@%0d", inst, e.cyc), v, 1);
                if (inst == 0) void'(q0.pop_front());
                else           void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clock) begin
        monitor(0, grant0, sel0, valid0, dout0);
        monitor(1, grant1, sel1, valid1, dout1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1);
        reset = 1'b1;
    endtask

    function automatic logic [6:0] dval(input int i);
        case (i)
            0:       return 7'h11;
            1:       return 7'h22;
            2:       return 7'h2A;
            default: return 7'h33;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        req0  = '0;
        req1  = '0;
        D0 = 7'h11; D1 = 7'h22; D2 = 7'h2A; D3 = 7'h33;
        #1 reset = 1'b0;
        step(1);
        chk("reset_grant", grant0, 0);
        chk("reset_valid", valid0, 0);
        chk("reset_sel", sel0, 0);
        chk("reset_dout", dout0, 0);
        reset = 1'b1;

        // Single requester 2, held for three edges
        c = cyc; req0 = 4'b0100;
        push(0, c + 1, 3, 2, 7'h2A);
        step(3); req0 = '0; step(3);

        // All four requesting: 8-cycle slots, one-cycle gaps, rotation 0..3,0
        do_reset();
        c = cyc; req0 = 4'b1111;
        for (int k = 0; k < 5; k++) push(0, c + 1 + 9 * k, 8, k % 4, dval(k % 4));
        step(44); req0 = '0; step(3);

        // Pointer wrap after a grant on requester 3
        do_reset();
        c = cyc; req0 = 4'b1000;
        push(0, c + 1, 2, 3, 7'h33);
        step(2); req0 = '0;
        step(1); req0 = 4'b1001;
        push(0, c + 4, 2, 0, 7'h11);
        step(2); req0 = '0; step(3);

        // Saturated lone owner, then preempted by requester 0
        do_reset();
        c = cyc; req0 = 4'b0010;
        push(0, c + 1, 20, 1, 7'h22);
        step(20); req0 = 4'b0011;
        push(0, c + 22, 3, 0, 7'h11);
        step(2); req0 = 4'b0001;
        step(2); req0 = '0; step(3);

        // Asynchronous reset in the middle of a grant
        do_reset();
        c = cyc; req0 = 4'b0100;
        push(0, c + 1, 2, 2, 7'h2A);
        step(3); reset = 1'b0;
        #1;
        chk("async_reset_grant", grant0, 0);
        chk("async_reset_valid", valid0, 0);
        chk("async_reset_sel", sel0, 0);
        chk("async_reset_dout", dout0, 0);
        req0 = '0;
        step(1); reset = 1'b1;
        c = cyc; req0 = 4'b1000;
        push(0, c + 1, 2, 3, 7'h33);
        step(2); req0 = '0; step(3);

        // Release and new request on the same edge
        do_reset();
        c = cyc; req0 = 4'b0010;
        push(0, c + 1, 2, 1, 7'h22);
        step(2); req0 = 4'b0100;
        push(0, c + 4, 2, 2, 7'h2A);
        step(3); req0 = '0; step(3);

        // SLOT=1 contention: single-cycle grants alternating 0/1
        c = cyc; req1 = 4'b0011;
        for (int k = 0; k < 6; k++) push(1, c + 1 + 2 * k, 1, k % 2, (k % 2 == 1) ? 7'h22 : 7'h11);
        step(11); req1 = '0; step(3);

        chk("dut0_pending_left", q0.size(), 0);
        chk("dut1_pending_left", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
